// File: rtl/mem_pkg.sv
// Shared constants for the data-memory access unit: FSM state codes, RV64I
// load/store funct3 encodings and the default bus timeout.
package mem_pkg;

  localparam int unsigned TimeoutDefault = 16;

  typedef logic [1:0] state_t;
  localparam state_t StIdle = 2'd0;
  localparam state_t StReq  = 2'd1;
  localparam state_t StWait = 2'd2;
  localparam state_t StDone = 2'd3;

  localparam logic [2:0] Lb  = 3'b000;
  localparam logic [2:0] Lh  = 3'b001;
  localparam logic [2:0] Lw  = 3'b010;
  localparam logic [2:0] Ld  = 3'b011;
  localparam logic [2:0] Lbu = 3'b100;
  localparam logic [2:0] Lhu = 3'b101;
  localparam logic [2:0] Lwu = 3'b110;
  localparam logic [2:0] Sb  = 3'b000;
  localparam logic [2:0] Sh  = 3'b001;
  localparam logic [2:0] Sw  = 3'b010;
  localparam logic [2:0] Sd  = 3'b011;

  // Natural alignment check; size comes from funct3[1:0] for loads and stores alike.
  function automatic logic is_aligned(input logic [1:0] size, input logic [2:0] a);
    case (size)
      2'b00:   is_aligned = 1'b1;
      2'b01:   is_aligned = (a[0] == 1'b0);
      2'b10:   is_aligned = (a[1:0] == 2'b00);
      default: is_aligned = (a == 3'b000);
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory request/response bus between the access unit and the memory.
interface mem_access_unit_if;
  logic        req;
  logic        we;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        gnt;
  logic        rvalid;
  logic [63:0] rdata;

  modport master (
    output req, we, addr, wdata, wstrb,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, wstrb,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/mem_load_align.sv
// Extracts the addressed bytes from a 64-bit memory word and sign/zero-extends
// them according to the load funct3.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [2:0]  a,
  input  logic [2:0]  funct3,
  output logic [63:0] value
);

  logic [63:0] shifted;

  always_comb begin
    shifted = rdata >> {a, 3'b000};
    case (funct3)
      Lb:      value = {{56{shifted[7]}}, shifted[7:0]};
      Lh:      value = {{48{shifted[15]}}, shifted[15:0]};
      Lw:      value = {{32{shifted[31]}}, shifted[31:0]};
      Lbu:     value = {56'd0, shifted[7:0]};
      Lhu:     value = {48'd0, shifted[15:0]};
      Lwu:     value = {32'd0, shifted[31:0]};
      default: value = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: checks alignment, runs the data-memory handshake
// with a timeout, and stalls the pipeline until the access completes.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = TimeoutDefault
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ex_mem_valid,
  input  logic               ex_mem_mem_read,
  input  logic               ex_mem_mem_write,
  input  logic [2:0]         ex_mem_funct3,
  input  logic [63:0]        ex_mem_result,
  input  logic [63:0]        ex_mem_store_data,
  input  logic [4:0]         ex_mem_rd,
  input  logic               ex_mem_regWrite,
  input  logic               ex_mem_MemtoReg,
  mem_access_unit_if.master  dmem,
  output logic               stall,
  output logic [4:0]         mem_rd,
  output logic [63:0]        mem_result,
  output logic [63:0]        mem_read_data,
  output logic               mem_regWrite,
  output logic               mem_MemtoReg,
  output logic               mem_exc,
  output logic               bus_err,
  output logic [63:0]        exc_addr
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  state_t      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [63:0] load_q, load_d;
  logic        bus_err_q, bus_err_d;
  logic [63:0] addr_q, sdata_q;
  logic [2:0]  funct3_q;
  logic [4:0]  rd_q;
  logic        regwrite_q, memtoreg_q, is_store_q;

  logic        mem_op, legal, access_ok, start, cnt_last;
  logic [63:0] load_value;

  assign mem_op    = ex_mem_valid & (ex_mem_mem_read | ex_mem_mem_write);
  assign legal     = ex_mem_mem_write ? ~ex_mem_funct3[2] : (ex_mem_funct3 != 3'b111);
  assign access_ok = legal & is_aligned(ex_mem_funct3[1:0], ex_mem_result[2:0]);
  assign start     = (state_q == StIdle) & mem_op & access_ok;
  assign cnt_last  = (cnt_q == CntW'(TIMEOUT - 1));

  mem_load_align u_load_align (
    .rdata  (dmem.rdata),
    .a      (addr_q[2:0]),
    .funct3 (funct3_q),
    .value  (load_value)
  );

  // Handshake events take priority over a timeout landing in the same cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    load_d    = load_q;
    bus_err_d = bus_err_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StReq;
          cnt_d     = '0;
          bus_err_d = 1'b0;
        end
      end
      StReq: begin
        cnt_d = cnt_q + CntW'(1);
        if (dmem.gnt) begin
          state_d = is_store_q ? StDone : StWait;
        end else if (cnt_last) begin
          state_d   = StDone;
          bus_err_d = 1'b1;
        end
      end
      StWait: begin
        cnt_d = cnt_q + CntW'(1);
        if (dmem.rvalid) begin
          load_d  = load_value;
          state_d = StDone;
        end else if (cnt_last) begin
          state_d   = StDone;
          bus_err_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      load_q     <= '0;
      bus_err_q  <= 1'b0;
      addr_q     <= '0;
      sdata_q    <= '0;
      funct3_q   <= '0;
      rd_q       <= '0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      is_store_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      load_q    <= load_d;
      bus_err_q <= bus_err_d;
      if (start) begin
        addr_q     <= ex_mem_result;
        sdata_q    <= ex_mem_store_data;
        funct3_q   <= ex_mem_funct3;
        rd_q       <= ex_mem_rd;
        regwrite_q <= ex_mem_regWrite;
        memtoreg_q <= ex_mem_MemtoReg;
        is_store_q <= ex_mem_mem_write;
      end
    end
  end

  // Request fields come only from the latched copy, so EX/MEM may change freely.
  always_comb begin
    dmem.req   = (state_q == StReq);
    dmem.we    = is_store_q;
    dmem.addr  = {addr_q[63:3], 3'b000};
    dmem.wdata = sdata_q << {addr_q[2:0], 3'b000};
    dmem.wstrb = 8'h00;
    if (is_store_q) begin
      case (funct3_q[1:0])
        2'b00:   dmem.wstrb = 8'h01 << addr_q[2:0];
        2'b01:   dmem.wstrb = 8'h03 << addr_q[2:0];
        2'b10:   dmem.wstrb = 8'h0F << addr_q[2:0];
        default: dmem.wstrb = 8'hFF;
      endcase
    end
  end

  always_comb begin
    stall         = 1'b0;
    mem_rd        = ex_mem_rd;
    mem_result    = ex_mem_result;
    mem_read_data = '0;
    mem_regWrite  = 1'b0;
    mem_MemtoReg  = ex_mem_MemtoReg;
    mem_exc       = 1'b0;
    bus_err       = 1'b0;
    exc_addr      = '0;
    case (state_q)
      StIdle: begin
        if (mem_op && !access_ok) begin
          mem_exc  = 1'b1;
          exc_addr = ex_mem_result;
        end else if (start) begin
          stall = 1'b1;
        end else begin
          mem_regWrite = ex_mem_valid & ex_mem_regWrite;
        end
      end
      StReq, StWait: begin
        stall = 1'b1;
      end
      default: begin
        mem_rd        = rd_q;
        mem_result    = addr_q;
        mem_read_data = load_q;
        mem_regWrite  = regwrite_q & ~bus_err_q;
        mem_MemtoReg  = memtoreg_q;
        bus_err       = bus_err_q;
        exc_addr      = bus_err_q ? addr_q : 64'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a table of load/store vectors served by a
// small memory responder, plus hand-written reset and pass-through sequences.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_mem_valid, ex_mem_mem_read, ex_mem_mem_write;
  logic [2:0]  ex_mem_funct3;
  logic [63:0] ex_mem_result, ex_mem_store_data;
  logic [4:0]  ex_mem_rd;
  logic        ex_mem_regWrite, ex_mem_MemtoReg;
  logic        stall;
  logic [4:0]  mem_rd;
  logic [63:0] mem_result, mem_read_data, exc_addr;
  logic        mem_regWrite, mem_MemtoReg, mem_exc, bus_err;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_unit_if dmem ();

  mem_access_unit #(.TIMEOUT(16)) dut (
    .clk               (clk),
    .reset             (reset),
    .ex_mem_valid      (ex_mem_valid),
    .ex_mem_mem_read   (ex_mem_mem_read),
    .ex_mem_mem_write  (ex_mem_mem_write),
    .ex_mem_funct3     (ex_mem_funct3),
    .ex_mem_result     (ex_mem_result),
    .ex_mem_store_data (ex_mem_store_data),
    .ex_mem_rd         (ex_mem_rd),
    .ex_mem_regWrite   (ex_mem_regWrite),
    .ex_mem_MemtoReg   (ex_mem_MemtoReg),
    .dmem              (dmem.master),
    .stall             (stall),
    .mem_rd            (mem_rd),
    .mem_result        (mem_result),
    .mem_read_data     (mem_read_data),
    .mem_regWrite      (mem_regWrite),
    .mem_MemtoReg      (mem_MemtoReg),
    .mem_exc           (mem_exc),
    .bus_err           (bus_err),
    .exc_addr          (exc_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    bit          st;
    logic [63:0] addr;
    logic [63:0] sdata;
    logic [63:0] rdata;
    int          gnt_dly;
    bit          exc;
    bit          tmo;
    logic [63:0] e_daddr;
    logic [7:0]  e_wstrb;
    logic [63:0] e_data;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    ex_mem_valid      = 1'b0;
    ex_mem_mem_read   = 1'b0;
    ex_mem_mem_write  = 1'b0;
    ex_mem_funct3     = 3'b000;
    ex_mem_result     = 64'd0;
    ex_mem_store_data = 64'd0;
    ex_mem_rd         = 5'd0;
    ex_mem_regWrite   = 1'b0;
    ex_mem_MemtoReg   = 1'b0;
  endtask

  task automatic drive_access(input vec_t v);
    ex_mem_valid      = 1'b1;
    ex_mem_mem_read   = !v.st;
    ex_mem_mem_write  = v.st;
    ex_mem_funct3     = v.f3;
    ex_mem_result     = v.addr;
    ex_mem_store_data = v.sdata;
    ex_mem_rd         = 5'd7;
    ex_mem_regWrite   = !v.st;
    ex_mem_MemtoReg   = !v.st;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int stalls, reqs, exp_stalls;
    bit granted, done, wchk;
    @(negedge clk);
    drive_access(v);
    #1;
    if (v.exc) begin
      chk($sformatf("v%0d exc stall", idx), stall, 0);
      chk($sformatf("v%0d exc req", idx), dmem.req, 0);
      chk($sformatf("v%0d exc flag", idx), mem_exc, 1);
      chk($sformatf("v%0d exc addr", idx), exc_addr, v.addr);
      chk($sformatf("v%0d exc regwrite", idx), mem_regWrite, 0);
      @(negedge clk);
      idle_inputs();
      #1;
      chk($sformatf("v%0d exc stays idle", idx), {stall, dmem.req}, 0);
      return;
    end
    chk($sformatf("v%0d issue stall", idx), stall, 1);
    chk($sformatf("v%0d issue no req", idx), dmem.req, 0);
    stalls = 1; reqs = 0; granted = 0; done = 0; wchk = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      dmem.gnt          = 1'b0;
      dmem.rvalid       = 1'b0;
      ex_mem_valid      = 1'b0;
      ex_mem_result     = 64'hDEAD_0000_0000_0001;
      ex_mem_store_data = ~v.sdata;
      ex_mem_funct3     = ~v.f3;
      ex_mem_rd         = 5'd30;
      #1;
      if (!stall) begin
        done = 1;
        exp_stalls = v.tmo ? 17 : ((v.st ? 2 : 3) + v.gnt_dly);
        chk($sformatf("v%0d stall cycles", idx), 64'(stalls), 64'(exp_stalls));
        chk($sformatf("v%0d bus_err", idx), bus_err, v.tmo);
        chk($sformatf("v%0d mem_exc", idx), mem_exc, 0);
        chk($sformatf("v%0d regwrite", idx), mem_regWrite, !v.st && !v.tmo);
        chk($sformatf("v%0d mem_rd", idx), mem_rd, 7);
        chk($sformatf("v%0d mem_result", idx), mem_result, v.addr);
        chk($sformatf("v%0d memtoreg", idx), mem_MemtoReg, !v.st);
        if (v.tmo) chk($sformatf("v%0d exc_addr", idx), exc_addr, v.addr);
        else if (!v.st) chk($sformatf("v%0d read_data", idx), mem_read_data, v.e_data);
      end else begin
        stalls++;
        if (dmem.req) begin
          if (!wchk) begin
            wchk = 1;
            chk($sformatf("v%0d dmem_addr", idx), dmem.addr, v.e_daddr);
            chk($sformatf("v%0d dmem_we", idx), dmem.we, v.st);
            if (v.st) begin
              chk($sformatf("v%0d wstrb", idx), dmem.wstrb, v.e_wstrb);
              chk($sformatf("v%0d wdata", idx), dmem.wdata, v.e_data);
            end
          end
          // A response outside WAIT must be ignored.
          dmem.rvalid = 1'b1;
          dmem.rdata  = ~v.rdata;
          if (reqs == v.gnt_dly) begin
            dmem.gnt = 1'b1;
            granted  = 1;
          end
          reqs++;
        end else if (granted) begin
          dmem.gnt    = 1'b1;
          dmem.rvalid = 1'b1;
          dmem.rdata  = v.rdata;
        end
      end
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL v%0d completion: still stalled after 40 cycles, expected DONE", idx);
    end
    @(negedge clk);
    dmem.gnt    = 1'b0;
    dmem.rvalid = 1'b0;
    idle_inputs();
    #1;
    chk($sformatf("v%0d back idle", idx), {stall, dmem.req}, 0);
  endtask

  initial begin
    //          f3  st addr          sdata                  rdata                  dly exc tmo daddr         wstrb  data
    vecs[0]  = '{Ld,  0, 64'h1000, 64'h0,                 64'h1122334455667788,  0, 0, 0, 64'h1000, 8'h00, 64'h1122334455667788};
    vecs[1]  = '{Lb,  0, 64'h1003, 64'h0,                 64'h0000000080000000,  0, 0, 0, 64'h1000, 8'h00, 64'hFFFFFFFFFFFFFF80};
    vecs[2]  = '{Lbu, 0, 64'h1003, 64'h0,                 64'h0000000080000000,  0, 0, 0, 64'h1000, 8'h00, 64'h0000000000000080};
    vecs[3]  = '{Lh,  0, 64'h1006, 64'h0,                 64'h8001000000000000,  1, 0, 0, 64'h1000, 8'h00, 64'hFFFFFFFFFFFF8001};
    vecs[4]  = '{Lhu, 0, 64'h1006, 64'h0,                 64'h8001000000000000,  0, 0, 0, 64'h1000, 8'h00, 64'h0000000000008001};
    vecs[5]  = '{Lw,  0, 64'h2004, 64'h0,                 64'h89ABCDEF00000000,  2, 0, 0, 64'h2000, 8'h00, 64'hFFFFFFFF89ABCDEF};
    vecs[6]  = '{Lwu, 0, 64'h2004, 64'h0,                 64'h89ABCDEF00000000,  0, 0, 0, 64'h2000, 8'h00, 64'h0000000089ABCDEF};
    vecs[7]  = '{Sh,  1, 64'h2006, 64'hABCD,              64'h0,                 0, 0, 0, 64'h2000, 8'hC0, 64'hABCD000000000000};
    vecs[8]  = '{Sb,  1, 64'h3005, 64'h5A,                64'h0,                 1, 0, 0, 64'h3000, 8'h20, 64'h00005A0000000000};
    vecs[9]  = '{Sw,  1, 64'h3004, 64'hDEADBEEF,          64'h0,                 0, 0, 0, 64'h3000, 8'hF0, 64'hDEADBEEF00000000};
    vecs[10] = '{Sd,  1, 64'h3008, 64'h0123456789ABCDEF,  64'h0,                 3, 0, 0, 64'h3008, 8'hFF, 64'h0123456789ABCDEF};
    vecs[11] = '{Lw,  0, 64'h1002, 64'h0,                 64'h0,                 0, 1, 0, 64'h0,    8'h00, 64'h0};
    vecs[12] = '{Ld,  0, 64'h1004, 64'h0,                 64'h0,                 0, 1, 0, 64'h0,    8'h00, 64'h0};
    vecs[13] = '{Sh,  1, 64'h2001, 64'h0,                 64'h0,                 0, 1, 0, 64'h0,    8'h00, 64'h0};
    vecs[14] = '{3'b111, 0, 64'h1000, 64'h0,              64'h0,                 0, 1, 0, 64'h0,    8'h00, 64'h0};
    vecs[15] = '{3'b100, 1, 64'h1000, 64'h0,              64'h0,                 0, 1, 0, 64'h0,    8'h00, 64'h0};
    vecs[16] = '{Ld,  0, 64'h4008, 64'h0,                 64'h0,                99, 0, 1, 64'h4008, 8'h00, 64'h0};

    idle_inputs();
    dmem.gnt    = 1'b0;
    dmem.rvalid = 1'b0;
    dmem.rdata  = 64'd0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset req", dmem.req, 0);
    chk("reset stall", stall, 0);
    chk("reset mem_exc", mem_exc, 0);
    chk("reset bus_err", bus_err, 0);

    // Non-memory instruction passes straight through.
    @(negedge clk);
    ex_mem_valid    = 1'b1;
    ex_mem_result   = 64'h55;
    ex_mem_rd       = 5'd3;
    ex_mem_regWrite = 1'b1;
    #1;
    chk("pass stall", stall, 0);
    chk("pass req", dmem.req, 0);
    chk("pass result", mem_result, 64'h55);
    chk("pass rd", mem_rd, 3);
    chk("pass regwrite", mem_regWrite, 1);
    chk("pass exc", mem_exc, 0);
    @(negedge clk);
    idle_inputs();

    for (int i = 0; i < 17; i++) run_vec(i, vecs[i]);

    // Reset while waiting for read data, followed by a stale response.
    @(negedge clk);
    drive_access(vecs[0]);
    @(negedge clk);
    idle_inputs();
    dmem.gnt = 1'b1;
    #1;
    chk("rst-wait in req", dmem.req, 1);
    @(negedge clk);
    dmem.gnt = 1'b0;
    #1;
    chk("rst-wait in wait", {stall, dmem.req}, 2'b10);
    reset = 1'b1;
    @(negedge clk);
    reset       = 1'b0;
    dmem.rvalid = 1'b1;
    dmem.rdata  = 64'hCAFE_F00D_CAFE_F00D;
    #1;
    chk("rst-wait stall", stall, 0);
    chk("rst-wait req", dmem.req, 0);
    @(negedge clk);
    dmem.rvalid = 1'b0;
    #1;
    chk("rst-wait no stall", stall, 0);
    chk("rst-wait no writeback", mem_regWrite, 0);
    chk("rst-wait read_data", mem_read_data, 0);
    chk("rst-wait bus_err", bus_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
